sync_debounce_bank: RTL

- Parametrised multi-channel input conditioner for asynchronous board inputs such as push-buttons and switches.
- Each channel has a configurable-depth synchronizer chain, followed by a symmetric counter-based debouncer and single-cycle edge pulses.
- It replaces per-signal fixed three-flop AND-type synchronizers, which debounce only the rising level.
- It sits between the top-level pins and the control FSMs.

---
 rtl/sync_debounce_bank.sv | 65 ++++++
 1 files changed

// File: rtl/sync_debounce_bank.sv
// Per-channel input conditioner: SYNC_STAGES-deep synchronizer, symmetric counter debouncer, registered edge pulses.
// Latency SYNC_STAGES + DEBOUNCE_CYCLES edges with sample_en held high; no backpressure, outputs always valid.
module sync_debounce_bank #(
    parameter int CHANNELS        = 4,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter bit RESET_LEVEL     = 1'b0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                sample_en,
    input  logic [CHANNELS-1:0] din,
    output logic [CHANNELS-1:0] dout,
    output logic [CHANNELS-1:0] rise,
    output logic [CHANNELS-1:0] fall
);

    localparam int             CW   = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0]  TERM = CW'(DEBOUNCE_CYCLES - 1);

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic [SYNC_STAGES-1:0] sync_q;
        logic [CW-1:0]          cnt;
        logic                   dout_q;
        logic                   rise_q;
        logic                   fall_q;
        logic                   s;
        logic                   diff;
        logic                   done;

        assign s    = sync_q[SYNC_STAGES-1];
        assign diff = s ^ dout_q;
        // The s == dout comparison wins over reaching the terminal count.
        assign done = diff && sample_en && (cnt == TERM);

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                sync_q <= {SYNC_STAGES{RESET_LEVEL}};
                cnt    <= '0;
                dout_q <= RESET_LEVEL;
                rise_q <= 1'b0;
                fall_q <= 1'b0;
            end else begin
                sync_q <= {sync_q[SYNC_STAGES-2:0], din[i]};
                rise_q <= done & s;
                fall_q <= done & ~s;
                if (!diff) begin
                    cnt <= '0;
                end else if (sample_en) begin
                    if (cnt == TERM) begin
                        dout_q <= s;
                        cnt    <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
            end
        end

        assign dout[i] = dout_q;
        assign rise[i] = rise_q;
        assign fall[i] = fall_q;
    end

endmodule
